// File: rtl/dsu_tile_loader_pkg.sv
// Shared accelerator definitions: bank occupancy states and the data/tile
// geometry defaults that the loader and DSU agree on.
package dsu_tile_loader_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  localparam int DSU_DATA_W   = 16;
  localparam int DSU_TILE_LEN = 16;

endpackage

// File: rtl/dsu_tile_loader_tile_bank_ram.sv
// One tile bank: single synchronous write port plus a registered read port.
// Contents are deliberately not reset; stale words are masked by the loader.
module tile_bank_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // write port and registered read port share the clock edge
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dsu_tile_loader.sv
// Ping-pong tile loader feeding DSU: packs an input word stream into two
// alternating banks and presents each completed tile through a read port.
module dsu_tile_loader
  import dsu_tile_loader_pkg::*;
#(
  parameter int DATA_W   = DSU_DATA_W,
  parameter int TILE_LEN = DSU_TILE_LEN,
  parameter int ADDR_W   = $clog2(TILE_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              tile_valid,
  output logic              tile_bank,
  output logic [ADDR_W:0]   tile_len,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              tile_done
);

  bank_state_e       r_state [2];
  bank_state_e       w_state_nxt [2];
  logic [ADDR_W:0]   r_len [2];
  logic [ADDR_W:0]   w_len_nxt [2];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] w_wr_ptr_nxt;
  logic              r_wr_bank;
  logic              w_wr_bank_nxt;
  logic              r_rd_bank;
  logic              w_rd_bank_nxt;
  logic              r_rd_zero;
  logic              r_rd_sel;
  logic              w_accept;
  logic              w_close;
  logic              w_release;
  logic              w_rd_in_range;
  logic [DATA_W-1:0] w_q [2];

  assign in_ready   = (r_state[r_wr_bank] != BANK_FULL);
  assign tile_valid = (r_state[r_rd_bank] == BANK_FULL);
  assign tile_bank  = r_rd_bank;
  assign tile_len   = r_len[r_rd_bank];

  assign w_accept  = in_valid && in_ready;
  assign w_close   = w_accept && ((r_wr_ptr == ADDR_W'(TILE_LEN - 1)) || in_last);
  assign w_release = tile_done && tile_valid;
  assign w_rd_in_range = ({1'b0, rd_addr} < tile_len);

  // next-state for bank occupancy, fill pointer and bank selectors
  always_comb begin
    w_state_nxt[0] = r_state[0];
    w_state_nxt[1] = r_state[1];
    w_len_nxt[0]   = r_len[0];
    w_len_nxt[1]   = r_len[1];
    w_wr_ptr_nxt   = r_wr_ptr;
    w_wr_bank_nxt  = r_wr_bank;
    w_rd_bank_nxt  = r_rd_bank;
    if (w_close) begin
      w_state_nxt[r_wr_bank] = BANK_FULL;
      w_len_nxt[r_wr_bank]   = {1'b0, r_wr_ptr} + (ADDR_W + 1)'(1);
      w_wr_ptr_nxt           = '0;
      w_wr_bank_nxt          = ~r_wr_bank;
    end else if (w_accept) begin
      w_state_nxt[r_wr_bank] = BANK_FILLING;
      w_wr_ptr_nxt           = r_wr_ptr + ADDR_W'(1);
    end else begin
      w_wr_ptr_nxt = r_wr_ptr;
    end
    // a released bank is FULL, so it can never be the bank being written
    if (w_release) begin
      w_state_nxt[r_rd_bank] = BANK_EMPTY;
      w_rd_bank_nxt          = ~r_rd_bank;
    end else begin
      w_rd_bank_nxt = r_rd_bank;
    end
  end

  // control state registers; a reset drops any partial tile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state[0] <= BANK_EMPTY;
      r_state[1] <= BANK_EMPTY;
      r_len[0]   <= '0;
      r_len[1]   <= '0;
      r_wr_ptr   <= '0;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
    end else begin
      r_state[0] <= w_state_nxt[0];
      r_state[1] <= w_state_nxt[1];
      r_len[0]   <= w_len_nxt[0];
      r_len[1]   <= w_len_nxt[1];
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_wr_bank  <= w_wr_bank_nxt;
      r_rd_bank  <= w_rd_bank_nxt;
    end
  end

  // read-side qualifiers registered alongside the RAM read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_zero <= 1'b1;
      r_rd_sel  <= 1'b0;
    end else if (rd_en) begin
      r_rd_zero <= !(tile_valid && w_rd_in_range);
      r_rd_sel  <= r_rd_bank;
    end else begin
      r_rd_zero <= r_rd_zero;
      r_rd_sel  <= r_rd_sel;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    tile_bank_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (TILE_LEN),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk       (clk),
      .i_wr_en   (w_accept && (r_wr_bank == 1'(g))),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (in_data),
      .i_rd_en   (rd_en),
      .i_rd_addr (rd_addr),
      .o_rd_data (w_q[g])
    );
  end

  assign rd_data = r_rd_zero ? '0 : w_q[r_rd_sel];

endmodule

// File: tb/tb_dsu_tile_loader.sv
// Directed bench for dsu_tile_loader: inputs change on the falling edge,
// outputs are checked on the falling edge before the next change.
module tb_dsu_tile_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        tile_valid;
  logic        tile_bank;
  logic [4:0]  tile_len;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        tile_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dsu_tile_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .tile_valid (tile_valid),
    .tile_bank  (tile_bank),
    .tile_len   (tile_len),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .tile_done  (tile_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    chk("in_ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] exp, input string tag);
    rd_en   = 1'b1;
    rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic done_pulse();
    tile_done = 1'b1;
    @(negedge clk);
    tile_done = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},   32'(in_ready),   32'd1);
    chk({tag, "_tile_valid"}, 32'(tile_valid), 32'd0);
    chk({tag, "_tile_bank"},  32'(tile_bank),  32'd0);
    chk({tag, "_tile_len"},   32'(tile_len),   32'd0);
    chk({tag, "_rd_data"},    32'(rd_data),    32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'd0;
    in_last   = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = 4'd0;
    tile_done = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // basic full tile into bank 0
    for (int i = 0; i < 16; i++) send(16'(i), 1'b0);
    chk("basic_valid", 32'(tile_valid), 32'd1);
    chk("basic_bank",  32'(tile_bank),  32'd0);
    chk("basic_len",   32'(tile_len),   32'd16);
    chk("basic_ready", 32'(in_ready),   32'd1);
    for (int i = 0; i < 16; i++) rd(4'(i), 16'(i), "basic_rd");
    done_pulse();
    chk("basic_released", 32'(tile_valid), 32'd0);

    // short tile lands in bank 1
    for (int i = 0; i < 5; i++) send(16'hA0 + 16'(i), (i == 4) ? 1'b1 : 1'b0);
    chk("short_valid", 32'(tile_valid), 32'd1);
    chk("short_bank",  32'(tile_bank),  32'd1);
    chk("short_len",   32'(tile_len),   32'd5);
    rd(4'd2, 16'hA2, "short_rd2");
    rd(4'd7, 16'h0,  "short_rd_oob");
    rd(4'd4, 16'hA4, "short_rd4");
    done_pulse();

    // spurious done and read with nothing presented
    done_pulse();
    chk("spur_valid", 32'(tile_valid), 32'd0);
    chk("spur_bank",  32'(tile_bank),  32'd0);
    chk("spur_ready", 32'(in_ready),   32'd1);
    rd(4'd0, 16'h0, "spur_rd");

    // ping-pong stall: 32 words fill both banks, word 33 waits
    for (int i = 1; i <= 32; i++) send(16'd100 + 16'(i), 1'b0);
    chk("stall_ready", 32'(in_ready),   32'd0);
    chk("stall_valid", 32'(tile_valid), 32'd1);
    chk("stall_bank",  32'(tile_bank),  32'd0);
    in_valid = 1'b1;
    in_data  = 16'd133;
    repeat (3) begin
      @(negedge clk);
      chk("stall_hold_ready", 32'(in_ready),  32'd0);
      chk("stall_hold_bank",  32'(tile_bank), 32'd0);
    end
    tile_done = 1'b1;
    @(negedge clk);
    tile_done = 1'b0;
    chk("stall_ready_rise", 32'(in_ready),   32'd1);
    chk("stall_bank_flip",  32'(tile_bank),  32'd1);
    chk("stall_valid_keep", 32'(tile_valid), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 34; i <= 40; i++) send(16'd100 + 16'(i), (i == 40) ? 1'b1 : 1'b0);
    chk("refill_ready", 32'(in_ready), 32'd0);
    rd(4'd15, 16'd132, "stall_rd_bank1");
    done_pulse();
    chk("refill_bank",  32'(tile_bank), 32'd0);
    chk("refill_len",   32'(tile_len),  32'd8);
    chk("refill_ready2", 32'(in_ready), 32'd1);
    rd(4'd0, 16'd133, "refill_rd0");
    rd(4'd7, 16'd140, "refill_rd7");
    rd(4'd8, 16'd0,   "refill_rd_oob");

    // last word of bank 1 coincides with release of bank 0
    for (int i = 1; i <= 3; i++) send(16'h50 + 16'(i), 1'b0);
    in_valid  = 1'b1;
    in_data   = 16'h54;
    in_last   = 1'b1;
    tile_done = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    tile_done = 1'b0;
    chk("simul_valid", 32'(tile_valid), 32'd1);
    chk("simul_bank",  32'(tile_bank),  32'd1);
    chk("simul_len",   32'(tile_len),   32'd4);
    chk("simul_ready", 32'(in_ready),   32'd1);
    rd(4'd3, 16'h54, "simul_rd3");
    done_pulse();

    // reset with bank 0 full and bank 1 partially filled
    for (int i = 0; i < 16; i++) send(16'd300 + 16'(i), 1'b0);
    for (int i = 0; i < 7; i++) send(16'd350 + 16'(i), 1'b0);
    chk("pre_reset_valid", 32'(tile_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) send(16'd400 + 16'(i), 1'b0);
    chk("post_reset_valid", 32'(tile_valid), 32'd1);
    chk("post_reset_bank",  32'(tile_bank),  32'd0);
    chk("post_reset_len",   32'(tile_len),   32'd16);
    rd(4'd0,  16'd400, "post_reset_rd0");
    rd(4'd6,  16'd406, "post_reset_rd6");
    rd(4'd15, 16'd415, "post_reset_rd15");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
